mips16_multicycle_ctrl: RTL and testbench
=========================================

# mips16_multicycle_ctrl

Multi-cycle control FSM for the 16-bit MIPS datapath. It sequences each instruction through fetch, decode, execute, memory and writeback. Each cycle it drives the select lines of the datapath's 2-, 3- and 4-input 16-bit muxes plus all register and memory write strobes. It sits beside the datapath, reads the opcode from the instruction register, and stalls on a memory-ready handshake.

## Interface
Parameters:
- none. Encodings are fixed in the shared package.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high; one clock domain.
- opcode  in  4  instr[15:12] from the instruction register.
- zero  in  1  ALU zero flag, used in BRANCH.
- mem_ready  in  1  memory completes the current read/write this cycle.
- pc_write, pc_write_cond, ir_write, mem_read, mem_write, reg_write  out  1 each  strobes.
- iord  out  1  address mux select: 0 = PC, 1 = ALUOut.
- alu_src_a  out  1  0 = PC, 1 = reg A.
- alu_src_b  out  2  00 = reg B, 01 = constant 1, 10 = sign-extended imm, 11 = branch offset.
- pc_source  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target, 11 = unused (datapath yields 0).
- reg_dst  out  1  0 = rt, 1 = rd.
- mem_to_reg  out  1  0 = ALUOut, 1 = MDR.
- alu_op  out  2  00 = add, 01 = sub, 10 = funct field.
- state  out  4  current state, for debug.
- illegal  out  1  one-cycle pulse on an unknown opcode.
- halted  out  1  high in HALT.

## Operation
- Opcodes:
  - 0000 = R-type
  - 0001 = ADDI
  - 0010 = LW
  - 0011 = SW
  - 0100 = BEQ
  - 0101 = J
  - 1111 = HALT
  - all others = illegal.
- Outputs are Moore: decoded from `state` only. Every strobe and select not listed for a state is 0.
- States and outputs:
  - FETCH(0): mem_read, iord=0, ir_write, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00, pc_write.
  - DECODE(1): alu_src_a=0, alu_src_b=11, alu_op=00 (precompute branch target).
  - MEM_ADDR(2): alu_src_a=1, alu_src_b=10, alu_op=00.
  - MEM_READ(3): mem_read, iord=1.
  - MEM_WB(4): reg_write, reg_dst=0, mem_to_reg=1.
  - MEM_WRITE(5): mem_write, iord=1.
  - EXECUTE(6): alu_src_a=1, alu_src_b=00, alu_op=10.
  - ALU_WB(7): reg_write, reg_dst=1, mem_to_reg=0.
  - BRANCH(8): alu_src_a=1, alu_src_b=00, alu_op=01, pc_source=01, pc_write_cond.
  - JUMP(9): pc_source=10, pc_write.
  - ADDI_EX(10): alu_src_a=1, alu_src_b=10, alu_op=00.
  - ADDI_WB(11): reg_write, reg_dst=0, mem_to_reg=0.
  - HALT(12): halted. All strobes 0.
- Transitions:
  - FETCH -> DECODE only when mem_ready. Otherwise hold FETCH.
  - DECODE by opcode:
    - R -> EXECUTE
    - ADDI -> ADDI_EX
    - LW/SW -> MEM_ADDR
    - BEQ -> BRANCH
    - J -> JUMP
    - HALT -> HALT
    - illegal -> FETCH, with illegal=1 for that one transition cycle. `illegal` is registered, so it is high during the next FETCH cycle only.
  - MEM_ADDR -> MEM_READ (LW) or MEM_WRITE (SW). The opcode is re-sampled here; IR is stable.
  - MEM_READ -> MEM_WB when mem_ready, else hold.
  - MEM_WRITE -> FETCH when mem_ready, else hold.
  - EXECUTE -> ALU_WB -> FETCH.
  - ADDI_EX -> ADDI_WB -> FETCH.
  - BRANCH -> FETCH.
  - JUMP -> FETCH.
  - HALT holds until reset.
- Strobe gating while stalled:
  - While waiting in FETCH, pc_write and ir_write are gated by mem_ready, so PC and IR update exactly once.
  - mem_read/mem_write stay high throughout the wait.
- pc_write_cond is a request. The datapath ANDs it with zero. The controller does not use zero for state transitions.

## Timing
- Cycle counts with mem_ready tied high:
  - BEQ, J: 3 cycles.
  - R, ADDI, SW: 4 cycles.
  - LW: 5 cycles.
- Each memory wait adds one cycle per cycle mem_ready is low.
- Reset:
  - Asynchronous assert forces state=FETCH and illegal=0.
  - While reset is high, all strobes are forced to 0; selects may show FETCH values.
  - The first fetch occurs on the first edge after deassertion.
  - Reset mid-instruction abandons it with no partial write: strobes drop immediately.
- Simultaneous events: reset dominates mem_ready and HALT.

## Structure
- Package mips16_ctrl_pkg holds:
  - state encodings (4-bit localparams)
  - opcode constants
  - alu_src_b, pc_source and alu_op encodings.
- One sub-module, mips16_ctrl_decode: a purely combinational state-to-control-word decoder. The top level holds the state register, next-state logic, the illegal register and mem_ready gating.

## Test plan
- Reset asserted mid-MEM_WB -> reg_write drops in the same cycle; after release, state=0 and FETCH outputs appear with pc_write=1.
- LW (0010) with mem_ready high -> states 0,1,2,3,4,0; reg_write=1 and mem_to_reg=1 only in state 4.
- SW with mem_ready low for 3 cycles in MEM_WRITE -> mem_write high for 4 cycles, then FETCH; no reg_write at any point.
- BEQ (0100) -> states 0,1,8,0; pc_write_cond=1 with pc_source=01 only in state 8. Same result for zero=0 and zero=1.
- Opcode 1010 -> states 0,1,0; illegal high for exactly one cycle. Then opcode 1111 -> HALT; halted=1 and no strobes for 20 cycles until reset.
- FETCH with mem_ready low for 2 cycles -> ir_write and pc_write each high for exactly one cycle, coinciding with mem_ready.

Source files
------------

// File: rtl/mips16_ctrl_pkg.sv
// Shared encodings for the 16-bit MIPS multi-cycle controller: states, opcodes,
// mux select values and the packed control word produced by the state decoder.
package mips16_ctrl_pkg;

  localparam logic [3:0] ST_FETCH     = 4'd0;
  localparam logic [3:0] ST_DECODE    = 4'd1;
  localparam logic [3:0] ST_MEM_ADDR  = 4'd2;
  localparam logic [3:0] ST_MEM_READ  = 4'd3;
  localparam logic [3:0] ST_MEM_WB    = 4'd4;
  localparam logic [3:0] ST_MEM_WRITE = 4'd5;
  localparam logic [3:0] ST_EXECUTE   = 4'd6;
  localparam logic [3:0] ST_ALU_WB    = 4'd7;
  localparam logic [3:0] ST_BRANCH    = 4'd8;
  localparam logic [3:0] ST_JUMP      = 4'd9;
  localparam logic [3:0] ST_ADDI_EX   = 4'd10;
  localparam logic [3:0] ST_ADDI_WB   = 4'd11;
  localparam logic [3:0] ST_HALT      = 4'd12;

  typedef enum logic [3:0] {
    S_FETCH     = ST_FETCH,
    S_DECODE    = ST_DECODE,
    S_MEM_ADDR  = ST_MEM_ADDR,
    S_MEM_READ  = ST_MEM_READ,
    S_MEM_WB    = ST_MEM_WB,
    S_MEM_WRITE = ST_MEM_WRITE,
    S_EXECUTE   = ST_EXECUTE,
    S_ALU_WB    = ST_ALU_WB,
    S_BRANCH    = ST_BRANCH,
    S_JUMP      = ST_JUMP,
    S_ADDI_EX   = ST_ADDI_EX,
    S_ADDI_WB   = ST_ADDI_WB,
    S_HALT      = ST_HALT
  } state_e;

  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_ADDI  = 4'b0001;
  localparam logic [3:0] OP_LW    = 4'b0010;
  localparam logic [3:0] OP_SW    = 4'b0011;
  localparam logic [3:0] OP_BEQ   = 4'b0100;
  localparam logic [3:0] OP_J     = 4'b0101;
  localparam logic [3:0] OP_HALT  = 4'b1111;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_ONE  = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BOFF = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       iord;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic       reg_dst;
    logic       mem_to_reg;
    logic [1:0] alu_op;
    logic       halted;
  } ctrl_t;

  function automatic logic is_legal_op(input logic [3:0] op);
    return (op inside {OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J, OP_HALT});
  endfunction

endpackage

// File: rtl/mips16_ctrl_decode.sv
// Pure Moore decode: maps the current state to the raw control word.
// Reset and memory-ready gating are applied by the parent.
module mips16_ctrl_decode
  import mips16_ctrl_pkg::*;
(
  input  state_e i_state,
  output ctrl_t  o_ctrl
);

  always_comb begin
    o_ctrl = '0;
    case (i_state)
      S_FETCH: begin
        o_ctrl.mem_read  = 1'b1;
        o_ctrl.ir_write  = 1'b1;
        o_ctrl.alu_src_b = SRCB_ONE;
        o_ctrl.alu_op    = ALUOP_ADD;
        o_ctrl.pc_source = PCSRC_ALU;
        o_ctrl.pc_write  = 1'b1;
      end
      S_DECODE: begin
        o_ctrl.alu_src_b = SRCB_BOFF;
        o_ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEM_ADDR, S_ADDI_EX: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_IMM;
        o_ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEM_READ: begin
        o_ctrl.mem_read = 1'b1;
        o_ctrl.iord     = 1'b1;
      end
      S_MEM_WB: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.mem_to_reg = 1'b1;
      end
      S_MEM_WRITE: begin
        o_ctrl.mem_write = 1'b1;
        o_ctrl.iord      = 1'b1;
      end
      S_EXECUTE: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_REG;
        o_ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_ALU_WB: begin
        o_ctrl.reg_write = 1'b1;
        o_ctrl.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        o_ctrl.alu_src_a     = 1'b1;
        o_ctrl.alu_src_b     = SRCB_REG;
        o_ctrl.alu_op        = ALUOP_SUB;
        o_ctrl.pc_source     = PCSRC_ALUOUT;
        o_ctrl.pc_write_cond = 1'b1;
      end
      S_JUMP: begin
        o_ctrl.pc_source = PCSRC_JUMP;
        o_ctrl.pc_write  = 1'b1;
      end
      S_ADDI_WB: begin
        o_ctrl.reg_write = 1'b1;
      end
      S_HALT: begin
        o_ctrl.halted = 1'b1;
      end
      default: o_ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mips16_multicycle_ctrl.sv
// Multi-cycle control FSM for the 16-bit MIPS datapath: state register, next-state
// logic, registered illegal-opcode pulse, and reset/memory-ready gating of strobes.
module mips16_multicycle_ctrl
  import mips16_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       ir_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic       iord,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_source,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic [1:0] alu_op,
  output logic [3:0] state,
  output logic       illegal,
  output logic       halted
);

  state_e r_state;
  state_e w_next;
  logic   r_illegal;
  ctrl_t  w_ctrl;
  logic   w_strobe_en;
  logic   w_fetch_done;
  logic   w_unused_zero;

  // Branch resolution happens in the datapath (pc_write_cond & zero).
  assign w_unused_zero = zero;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:     w_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:     w_next = S_EXECUTE;
          OP_ADDI:      w_next = S_ADDI_EX;
          OP_LW, OP_SW: w_next = S_MEM_ADDR;
          OP_BEQ:       w_next = S_BRANCH;
          OP_J:         w_next = S_JUMP;
          OP_HALT:      w_next = S_HALT;
          default:      w_next = S_FETCH;
        endcase
      end
      S_MEM_ADDR:  w_next = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  w_next = mem_ready ? S_MEM_WB : S_MEM_READ;
      S_MEM_WB:    w_next = S_FETCH;
      S_MEM_WRITE: w_next = mem_ready ? S_FETCH : S_MEM_WRITE;
      S_EXECUTE:   w_next = S_ALU_WB;
      S_ALU_WB:    w_next = S_FETCH;
      S_ADDI_EX:   w_next = S_ADDI_WB;
      S_ADDI_WB:   w_next = S_FETCH;
      S_BRANCH:    w_next = S_FETCH;
      S_JUMP:      w_next = S_FETCH;
      S_HALT:      w_next = S_HALT;
      default:     w_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_FETCH;
      r_illegal <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_illegal <= (r_state == S_DECODE) && !is_legal_op(opcode);
    end
  end

  mips16_ctrl_decode u_decode (
    .i_state (r_state),
    .o_ctrl  (w_ctrl)
  );

  // Strobes drop combinationally on reset so an abandoned instruction writes nothing.
  assign w_strobe_en  = ~reset;
  assign w_fetch_done = (r_state != S_FETCH) || mem_ready;

  assign pc_write      = w_ctrl.pc_write & w_fetch_done & w_strobe_en;
  assign ir_write      = w_ctrl.ir_write & w_fetch_done & w_strobe_en;
  assign pc_write_cond = w_ctrl.pc_write_cond & w_strobe_en;
  assign mem_read      = w_ctrl.mem_read & w_strobe_en;
  assign mem_write     = w_ctrl.mem_write & w_strobe_en;
  assign reg_write     = w_ctrl.reg_write & w_strobe_en;

  assign iord       = w_ctrl.iord;
  assign alu_src_a  = w_ctrl.alu_src_a;
  assign alu_src_b  = w_ctrl.alu_src_b;
  assign pc_source  = w_ctrl.pc_source;
  assign reg_dst    = w_ctrl.reg_dst;
  assign mem_to_reg = w_ctrl.mem_to_reg;
  assign alu_op     = w_ctrl.alu_op;
  assign halted     = w_ctrl.halted;
  assign state      = r_state;
  assign illegal    = r_illegal;

endmodule

// File: tb/tb_mips16_multicycle_ctrl.sv
// Random instruction stream with random memory stalls, checked against a model that
// walks each opcode's state path from a table, plus directed reset/illegal/HALT cases.
module tb_mips16_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, ir_write, mem_read, mem_write, reg_write;
  logic       iord, alu_src_a, reg_dst, mem_to_reg, illegal, halted;
  logic [1:0] alu_src_b, pc_source, alu_op;
  logic [3:0] state;
  logic [16:0] obs;
  logic [5:0]  strobes;

  mips16_multicycle_ctrl dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .ir_write(ir_write),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
    .iord(iord), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_source(pc_source),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_op(alu_op),
    .state(state), .illegal(illegal), .halted(halted)
  );

  always #5 clk = ~clk;

  assign obs = {pc_write, pc_write_cond, ir_write, mem_read, mem_write, reg_write,
                iord, alu_src_a, alu_src_b, pc_source, reg_dst, mem_to_reg, alu_op, halted};
  assign strobes = {pc_write, pc_write_cond, ir_write, mem_read, mem_write, reg_write};

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected outputs for a state, straight from the per-state output table.
  function automatic logic [16:0] exp_ctrl(input int st, input logic rdy);
    logic pw, pwc, irw, mr, mw, rw, io, sa, rd, m2r, hl;
    logic [1:0] sb, ps, ao;
    {pw, pwc, irw, mr, mw, rw, io, sa, rd, m2r, hl} = '0;
    sb = 2'b00; ps = 2'b00; ao = 2'b00;
    case (st)
      0:  begin mr = 1; irw = rdy; pw = rdy; sb = 2'b01; end
      1:  sb = 2'b11;
      2:  begin sa = 1; sb = 2'b10; end
      3:  begin mr = 1; io = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin mw = 1; io = 1; end
      6:  begin sa = 1; ao = 2'b10; end
      7:  begin rw = 1; rd = 1; end
      8:  begin sa = 1; ao = 2'b01; ps = 2'b01; pwc = 1; end
      9:  begin ps = 2'b10; pw = 1; end
      10: begin sa = 1; sb = 2'b10; end
      11: rw = 1;
      12: hl = 1;
      default: ;
    endcase
    return {pw, pwc, irw, mr, mw, rw, io, sa, sb, ps, rd, m2r, ao, hl};
  endfunction

  // Model: the state path each opcode takes; memory states repeat while mem_ready is low.
  int         path[6];
  int         plen;
  int         pos;
  logic [3:0] cur_op;
  logic       exp_ill;
  int         forced_op = -1;
  logic       rdy_hi    = 1'b0;

  task automatic set_path(input int n, input int a, input int b, input int c, input int d, input int e);
    plen = n;
    path[0] = a; path[1] = b; path[2] = c; path[3] = d; path[4] = e; path[5] = 0;
  endtask

  task automatic new_instr();
    if (forced_op >= 0) cur_op = 4'(forced_op);
    else if ($urandom_range(0, 99) < 85) cur_op = 4'($urandom_range(0, 5));
    else cur_op = 4'($urandom_range(6, 14));
    case (cur_op)
      4'd0:  set_path(4, 0, 1, 6, 7, 0);
      4'd1:  set_path(4, 0, 1, 10, 11, 0);
      4'd2:  set_path(5, 0, 1, 2, 3, 4);
      4'd3:  set_path(4, 0, 1, 2, 5, 0);
      4'd4:  set_path(3, 0, 1, 8, 0, 0);
      4'd5:  set_path(3, 0, 1, 9, 0, 0);
      4'd15: set_path(3, 0, 1, 12, 0, 0);
      default: set_path(2, 0, 1, 0, 0, 0);
    endcase
    pos = 0;
  endtask

  task automatic cycle();
    int st;
    @(negedge clk);
    mem_ready = rdy_hi ? 1'b1 : ($urandom_range(0, 3) != 0);
    zero      = 1'($urandom_range(0, 1));
    if (pos == 0) opcode = cur_op;
    #1;
    st = path[pos];
    check($sformatf("state op%0d", cur_op), 32'(state), 32'(st));
    check($sformatf("ctrl s%0d rdy%0d", st, mem_ready), 32'(obs), 32'(exp_ctrl(st, mem_ready)));
    check("illegal", 32'(illegal), 32'(exp_ill));
    exp_ill = 1'b0;
    if (st == 12) begin
    end else if ((st == 0 || st == 3 || st == 5) && !mem_ready) begin
    end else begin
      pos++;
      if (pos == plen) begin
        exp_ill = (st == 1);
        new_instr();
      end
    end
  endtask

  task automatic release_reset();
    @(posedge clk);
    #2;
    reset   = 1'b0;
    exp_ill = 1'b0;
    new_instr();
  endtask

  initial begin
    logic reached;
    reset = 1'b1; opcode = 4'd0; zero = 1'b0; mem_ready = 1'b1;
    #1;
    check("rst_state", 32'(state), 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);
    check("rst_strobes", 32'(strobes), 32'd0);
    release_reset();

    repeat (1500) cycle();

    // Reset while in MEM_WB: reg_write must drop without waiting for an edge.
    forced_op = 2; rdy_hi = 1'b1;
    for (int i = 0; i < 40 && !(cur_op == 4'd2 && path[pos] == 4); i++) cycle();
    reached = (cur_op == 4'd2 && path[pos] == 4);
    check("reach_memwb", 32'(reached), 32'd1);
    @(negedge clk);
    #1;
    check("memwb_rw", 32'(reg_write), 32'd1);
    reset = 1'b1;
    #1;
    check("midrst_rw", 32'(reg_write), 32'd0);
    check("midrst_state", 32'(state), 32'd0);
    check("midrst_strobes", 32'(strobes), 32'd0);
    forced_op = -1;
    release_reset();
    repeat (10) cycle();
    rdy_hi = 1'b0;
    repeat (200) cycle();

    // Illegal opcode stream, then HALT held for a long stretch.
    forced_op = 10;
    repeat (30) cycle();
    forced_op = 15;
    for (int i = 0; i < 80 && !(path[pos] == 12); i++) cycle();
    check("reach_halt", 32'(path[pos]), 32'd12);
    repeat (20) cycle();
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("halt_rst_state", 32'(state), 32'd0);
    check("halt_rst_halted", 32'(halted), 32'd0);
    forced_op = -1;
    release_reset();
    repeat (100) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
